// File: rtl/warmup_toy_pkg.sv
// Shared types and helpers for the warm-up-locked toy datapath.
package warmup_toy_pkg;

    // Operation encodings carried on the 2-bit op input.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_XOR  = 2'b10,
        OP_OUT  = 2'b11
    } op_t;

    // Upper bounds for the key vector and the warm-up step counter.
    localparam int MAX_KEY_BITS = 1024;
    localparam int STEP_W       = 8;

    // Lock state: warm-up step index plus the absorbing functional flag.
    typedef struct packed {
        logic              func;
        logic [STEP_W-1:0] step;
    } lock_state_t;

    localparam lock_state_t LOCK_RESET = '{func: 1'b0, step: '0};

    // Extracts key word idx (word_w bits each, word 0 in the LSBs), zero-extended.
    function automatic logic [MAX_KEY_BITS-1:0] key_word(
        input logic [MAX_KEY_BITS-1:0] key,
        input int unsigned             idx,
        input int unsigned             word_w
    );
        return (key >> (idx * word_w)) &
               ((MAX_KEY_BITS'(1) << word_w) - MAX_KEY_BITS'(1));
    endfunction

endpackage

// File: rtl/warmup_key_checker.sv
// Warm-up step counter: walks the key sequence and flags completion in done.
module warmup_key_checker
    import warmup_toy_pkg::*;
#(
    parameter int                          DW      = 8,
    parameter int                          KEY_LEN = 4,
    parameter logic [KEY_LEN*(DW+2)-1:0]   KEY     = {10'h2A5, 10'h15A, 10'h3C3, 10'h0F0}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    op,
    input  logic [DW-1:0] datain,
    output logic          done
);

    localparam int WW = DW + 2;
    localparam int KB = KEY_LEN * WW;

    lock_state_t             r_state;
    lock_state_t             w_state_next;
    logic [MAX_KEY_BITS-1:0] w_key_ext;
    logic [MAX_KEY_BITS-1:0] w_sample_ext;
    logic                    w_hit_step;
    logic                    w_hit_first;

    assign w_key_ext    = {{(MAX_KEY_BITS-KB){1'b0}}, KEY};
    assign w_sample_ext = {{(MAX_KEY_BITS-WW){1'b0}}, op, datain};
    assign w_hit_step   = (key_word(w_key_ext, 32'(r_state.step), WW) == w_sample_ext);
    assign w_hit_first  = (key_word(w_key_ext, 0, WW) == w_sample_ext);
    assign done         = r_state.func;

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOCK_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: advance on a match, fall back to step 1 or 0 on a miss, FUNC absorbs.
    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (!r_state.func) begin
            if (w_hit_step) begin
                if (r_state.step == STEP_W'(KEY_LEN - 1)) begin
                    w_state_next.func = 1'b1;
                    w_state_next.step = '0;
                end else begin
                    w_state_next.step = r_state.step + STEP_W'(1);
                end
            end else if (w_hit_first) begin
                w_state_next.step = STEP_W'(1);
            end else begin
                w_state_next.step = '0;
            end
        end
    end

endmodule

// File: rtl/warmup_locked_toy.sv
// Toy accumulator datapath that stays inert until the warm-up key has been applied.
module warmup_locked_toy
    import warmup_toy_pkg::*;
#(
    parameter int                          DW      = 8,
    parameter int                          KEY_LEN = 4,
    parameter logic [KEY_LEN*(DW+2)-1:0]   KEY     = {10'h2A5, 10'h15A, 10'h3C3, 10'h0F0},
    parameter bit                          SAT_ADD = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] datain,
    input  logic [1:0]    op,
    output logic [DW-1:0] dataout,
    output logic          valid,
    output logic          unlocked
);

    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_dataout;
    logic          r_valid;
    logic          w_unlocked;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_add;

    warmup_key_checker #(
        .DW      (DW),
        .KEY_LEN (KEY_LEN),
        .KEY     (KEY)
    ) u_key_checker (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .datain (datain),
        .done   (w_unlocked)
    );

    // Carry-out of the add selects the clamp when saturation is enabled.
    assign w_sum = {1'b0, r_acc} + {1'b0, datain};
    assign w_add = (SAT_ADD && w_sum[DW]) ? {DW{1'b1}} : w_sum[DW-1:0];

    // Functional datapath: only runs once the key checker reports done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_dataout <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_unlocked) begin
                unique case (op_t'(op))
                    OP_LOAD: r_acc <= datain;
                    OP_ADD:  r_acc <= w_add;
                    OP_XOR:  r_acc <= r_acc ^ datain;
                    OP_OUT: begin
                        r_dataout <= r_acc;
                        r_valid   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dataout  = r_dataout;
    assign valid    = r_valid;
    assign unlocked = w_unlocked;

endmodule
